magic_device_prefetch_arbiter: RTL and testbench

Multi-channel successor to the single-port magic data device. It serves CHANNELS independent read ports. Each port has its own prefetch FIFO of randomizer words. A single round-robin request engine refills the FIFOs from one shared data source (the DPI randomizer shim, `cosim_randomizer_data`, or an equivalent model). DUT-side readers see FWFT (first-word-fall-through) valid/ready ports, with no per-read DPI call on the critical path.

---
 rtl/magic_device_pkg.sv | 21 ++
 rtl/magic_prefetch_fifo.sv | 52 +++++
 rtl/magic_device_prefetch_arbiter.sv | 143 ++++++++++++++
 tb/tb_magic_device_prefetch_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/magic_device_pkg.sv
// Shared types and width helpers for the magic device prefetch arbiter.
// Holds the refill FSM state encoding and counter/channel width helpers.
package magic_device_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  // Count width: must hold 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Channel index width, at least one bit.
  function automatic int ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/magic_prefetch_fifo.sv
// Per-channel FWFT prefetch FIFO with registered count and flush.
// Ports: clock, reset (sync, active-low), push/push_data, pop, flush;
//        data (head, 0 when empty), valid, count.
module magic_prefetch_fifo
  import magic_device_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DATA_W = 64,
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  assign do_push = push && (count < CNT_W'(DEPTH));
  assign data    = valid ? mem[rd_ptr] : '0;

  // Flush wins over push and pop in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/magic_device_prefetch_arbiter.sv
// Multi-channel prefetch arbiter: round-robin refill of per-channel FWFT FIFOs
// from one shared source with a single outstanding request.
// Ports: clock, reset (sync, active-low); ch_en, rd_select, rd_ready in,
//        rd_valid, rd_data out; src_req_* / src_rsp_* source link; drop_count.
module magic_device_prefetch_arbiter
  import magic_device_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W = 12,
  parameter int DATA_W = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          ch_en,
  input  logic [CHANNELS*SEL_W-1:0]    rd_select,
  input  logic [CHANNELS-1:0]          rd_ready,
  output logic [CHANNELS-1:0]          rd_valid,
  output logic [CHANNELS*DATA_W-1:0]   rd_data,
  output logic                         src_req_valid,
  input  logic                         src_req_ready,
  output logic [SEL_W-1:0]             src_req_select,
  input  logic                         src_rsp_valid,
  input  logic [DATA_W-1:0]            src_rsp_data,
  output logic [15:0]                  drop_count
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int CH_W = ch_w(CHANNELS);

  state_t state;
  state_t state_nx;

  logic [CH_W-1:0]     chan_q;
  logic [CH_W-1:0]     rr_ptr;
  logic [CH_W-1:0]     grant;
  logic                any_elig;
  logic                discard;
  logic                grant_fire;
  logic                rsp_fire;
  logic                drop_now;
  logic [SEL_W-1:0]    sel_in [CHANNELS];
  logic [SEL_W-1:0]    sel_q  [CHANNELS];
  logic [CNT_W-1:0]    count  [CHANNELS];
  logic [CHANNELS-1:0] sel_chg;
  logic [CHANNELS-1:0] elig;
  logic [CHANNELS-1:0] push;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic inflight;

    assign sel_in[c]  = rd_select[c*SEL_W +: SEL_W];
    assign sel_chg[c] = (sel_in[c] != sel_q[c]);
    assign inflight   = (state != IDLE) && (chan_q == CH_W'(c));
    // A select change blocks the grant in the cycle its flush lands.
    assign elig[c] = ch_en[c] && !sel_chg[c] &&
                     ((count[c] + CNT_W'(inflight)) < CNT_W'(DEPTH));
    assign push[c] = rsp_fire && !drop_now && (chan_q == CH_W'(c));

    // Loading every cycle also covers the reset-time load.
    always_ff @(posedge clock) begin
      sel_q[c] <= sel_in[c];
    end

    magic_prefetch_fifo #(
      .DEPTH (DEPTH),
      .DATA_W(DATA_W)
    ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (push[c]),
      .push_data(src_rsp_data),
      .pop      (rd_ready[c]),
      .flush    (sel_chg[c]),
      .data     (rd_data[c*DATA_W +: DATA_W]),
      .valid    (rd_valid[c]),
      .count    (count[c])
    );
  end

  // Round-robin search starting at rr_ptr.
  always_comb begin
    logic [CH_W:0] idx;
    any_elig = 1'b0;
    grant    = '0;
    idx      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (idx >= (CH_W+1)'(CHANNELS)) idx = idx - (CH_W+1)'(CHANNELS);
      if (!any_elig && elig[idx[CH_W-1:0]]) begin
        any_elig = 1'b1;
        grant    = idx[CH_W-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_elig)      state_nx = REQ;
      REQ:     if (src_req_ready) state_nx = WAIT;
      WAIT:    if (src_rsp_valid) state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  // A word landing in the same cycle its channel's select changes
  // belongs to the old select, so it is dropped like a flagged one.
  always_comb begin
    src_req_valid = (state == REQ);
    grant_fire    = (state == IDLE) && any_elig;
    rsp_fire      = (state == WAIT) && src_rsp_valid;
    drop_now      = discard || sel_chg[chan_q];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      chan_q         <= '0;
      rr_ptr         <= '0;
      src_req_select <= '0;
      discard        <= 1'b0;
      drop_count     <= '0;
    end else begin
      if (grant_fire) begin
        chan_q         <= grant;
        src_req_select <= sel_in[grant];
        rr_ptr <= (32'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;
      end
      if (rsp_fire)
        discard <= 1'b0;
      else if ((state != IDLE) && sel_chg[chan_q])
        discard <= 1'b1;
      if (rsp_fire && drop_now && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_magic_device_prefetch_arbiter.sv
// Self-checking bench for magic_device_prefetch_arbiter.
// Source model with scoreboard queues per channel, plus phase table.
module tb_magic_device_prefetch_arbiter;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   ch_en = '0;
  logic [47:0]  rd_select;
  logic [3:0]   rd_ready = '0;
  logic [3:0]   rd_valid;
  logic [255:0] rd_data;
  logic         src_req_valid;
  logic         src_req_ready;
  logic [11:0]  src_req_select;
  logic         src_rsp_valid;
  logic [63:0]  src_rsp_data;
  logic [15:0]  drop_count;

  magic_device_prefetch_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .ch_en         (ch_en),
    .rd_select     (rd_select),
    .rd_ready      (rd_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .src_req_valid (src_req_valid),
    .src_req_ready (src_req_ready),
    .src_req_select(src_req_select),
    .src_rsp_valid (src_rsp_valid),
    .src_rsp_data  (src_rsp_data),
    .drop_count    (drop_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] en;
    int         pop0;
    int         cyc;
    logic [3:0] valid;
    int         reqs;
  } row_t;

  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_q [4][$];
  logic [11:0] sel_tab [4];
  int          acc_total = 0;
  int          acc_log [$];
  logic [11:0] sel_log [$];
  int          rsp_delay = 1;
  bit          ready_en = 1'b1;
  bit          kill_rsp = 1'b0;
  bit          pend = 1'b0;
  int          wait_cnt = 0;
  logic [11:0] pend_sel = '0;
  logic [63:0] next_data = 64'd1;
  row_t        rows [6];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int chan_of(input logic [11:0] s);
    for (int c = 0; c < 4; c++) if (sel_tab[c] == s) return c;
    return -1;
  endfunction

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Source: accepts when ready, answers rsp_delay cycles after accept.
  initial begin
    int sc;
    src_req_ready = 1'b0;
    src_rsp_valid = 1'b0;
    src_rsp_data  = '0;
    forever begin
      @(negedge clock);
      src_rsp_valid = 1'b0;
      if (pend) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          pend = 1'b0;
          src_rsp_valid = 1'b1;
          src_rsp_data  = next_data;
          if (kill_rsp) begin
            kill_rsp = 1'b0;
          end else begin
            sc = chan_of(pend_sel);
            if (sc >= 0) exp_q[sc].push_back(next_data);
          end
          next_data++;
        end
      end
      src_req_ready = ready_en;
      if (reset && src_req_valid && src_req_ready) begin
        pend     = 1'b1;
        wait_cnt = rsp_delay;
        pend_sel = src_req_select;
        acc_total++;
        acc_log.push_back(chan_of(src_req_select));
        sel_log.push_back(src_req_select);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    kill_rsp = pend;
    tick();
    tick();
    check("rst_valid", 64'(rd_valid), 64'h0);
    check("rst_data_zero", 64'(rd_data == '0), 64'h1);
    check("rst_req_valid", 64'(src_req_valid), 64'h0);
    check("rst_req_sel", 64'(src_req_select), 64'h0);
    check("rst_drop", 64'(drop_count), 64'h0);
    for (int c = 0; c < 4; c++) exp_q[c].delete();
    reset = 1'b1;
  endtask

  task automatic pop_n(input int c, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      check($sformatf("pop%0d_valid", c), 64'(rd_valid[c]), 64'h1);
      if (exp_q[c].size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop%0d_sb: got empty scoreboard want entry", c);
        rd_ready[c] = 1'b0;
        return;
      end
      check($sformatf("pop%0d_data", c), rd_data[c*64 +: 64],
            exp_q[c].pop_front());
      rd_ready[c] = 1'b1;
    end
    tick();
    rd_ready[c] = 1'b0;
  endtask

  task automatic quiesce();
    repeat (12) tick();
    check("quiet", {62'h0, pend, src_req_valid}, 64'h0);
  endtask

  task automatic drain(input int c);
    pop_n(c, exp_q[c].size());
    check($sformatf("drain%0d_empty", c), 64'(rd_valid[c]), 64'h0);
  endtask

  task automatic wait_accept();
    int base;
    base = acc_total;
    for (int k = 0; k < 20; k++) begin
      if (acc_total != base) return;
      tick();
    end
    total++;
    bad++;
    $display("FAIL accept_timeout: got no accept want accept");
  endtask

  initial begin
    int base;
    sel_tab[0] = 12'h001;
    sel_tab[1] = 12'h010;
    sel_tab[2] = 12'h100;
    sel_tab[3] = 12'h200;
    rd_select = {sel_tab[3], sel_tab[2], sel_tab[1], sel_tab[0]};

    rows[0] = '{en: 4'b0000, pop0: 0, cyc: 8,  valid: 4'b0000, reqs: 0};
    rows[1] = '{en: 4'b0001, pop0: 0, cyc: 20, valid: 4'b0001, reqs: 4};
    rows[2] = '{en: 4'b0001, pop0: 0, cyc: 10, valid: 4'b0001, reqs: 0};
    rows[3] = '{en: 4'b0001, pop0: 3, cyc: 20, valid: 4'b0001, reqs: 3};
    rows[4] = '{en: 4'b1111, pop0: 0, cyc: 45, valid: 4'b1111, reqs: 12};
    rows[5] = '{en: 4'b0000, pop0: 0, cyc: 10, valid: 4'b1111, reqs: 0};

    do_reset();

    // Phase table: fill ch0, hold, partial pop and refill, fill all.
    for (int r = 0; r < 6; r++) begin
      ch_en = rows[r].en;
      base = acc_total;
      if (rows[r].pop0 > 0) pop_n(0, rows[r].pop0);
      repeat (rows[r].cyc) tick();
      check($sformatf("row%0d_valid", r), 64'(rd_valid), 64'(rows[r].valid));
      check($sformatf("row%0d_reqs", r), 64'(acc_total - base),
            64'(rows[r].reqs));
    end
    for (int c = 0; c < 4; c++) drain(c);

    // Round-robin order from reset with all channels enabled.
    do_reset();
    acc_log.delete();
    ch_en = 4'b1111;
    repeat (60) tick();
    check("rr_count", 64'(acc_log.size()), 64'd16);
    for (int i = 0; i < 16 && i < acc_log.size(); i++)
      check($sformatf("rr_order%0d", i), 64'(acc_log[i]), 64'(i % 4));
    ch_en = 4'b0000;
    quiesce();
    for (int c = 0; c < 4; c++) drain(c);

    // Select change on ch1 while its request is outstanding.
    ch_en = 4'b0010;
    repeat (20) tick();
    check("ch1_full", 64'(rd_valid), 64'b0010);
    rsp_delay = 3;
    pop_n(1, 1);
    wait_accept();
    rd_select[23:12] = 12'h020;
    sel_tab[1] = 12'h020;
    exp_q[1].delete();
    sel_log.delete();
    tick();
    check("flush_valid", 64'(rd_valid[1]), 64'h0);
    repeat (6) tick();
    check("drop_count", 64'(drop_count), 64'd1);
    repeat (30) tick();
    check("resel", 64'((sel_log.size() > 0) ? sel_log[0] : 12'h0), 64'h020);
    ch_en = 4'b0000;
    quiesce();
    drain(1);
    rsp_delay = 1;

    // Backpressure: request must hold while not accepted.
    ready_en = 1'b0;
    tick();
    tick();
    ch_en = 4'b0001;
    for (int k = 0; k < 10 && !src_req_valid; k++) tick();
    base = acc_total;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("hold%0d", k), {51'h0, src_req_valid, src_req_select},
            {51'h0, 1'b1, sel_tab[0]});
    end
    check("hold_noacc", 64'(acc_total - base), 64'h0);
    ch_en = 4'b0000;
    ready_en = 1'b1;
    quiesce();
    check("hold_one_req", 64'(acc_total - base), 64'h1);
    drain(0);

    // Reset during WAIT, then a late response.
    rsp_delay = 4;
    ch_en = 4'b0001;
    wait_accept();
    tick();
    ch_en = 4'b0000;
    do_reset();
    repeat (5) tick();
    check("late_valid", 64'(rd_valid), 64'h0);
    check("late_drop", 64'(drop_count), 64'h0);
    check("late_req", 64'(src_req_valid), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
